// File: rtl/ace_rf_pkg.sv
// Shared defaults and types for the register file / scoreboard slice.
package ace_rf_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_SB_CNT_W = 2;
  localparam int REG_ZERO    = 0;

  typedef logic [RF_ADDR_W-1:0]   reg_addr_t;
  typedef logic [RF_SB_CNT_W-1:0] sb_cnt_t;
endpackage

// File: rtl/rf_sb_cell.sv
// One scoreboard entry: saturating up/down pending-write counter.
module rf_sb_cell
  import ace_rf_pkg::*;
#(
  parameter int CNT_W = RF_SB_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             zero,
  output logic             at_max
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  assign zero   = (cnt == '0);
  assign at_max = (cnt == CNT_MAX);

  // An issue and a retire on the same register cancel out.
  always_comb begin
    cnt_nxt = cnt;
    if (inc && !dec && !at_max)
      cnt_nxt = cnt + 1'b1;
    else if (dec && !inc && !zero)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset) dec |-> !zero);
endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file with bypassed read ports and pending-write scoreboard.
// Optional debug read port enabled by defining RF_DEBUG_PORT_EN.
module reg_file_sb
  import ace_rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int SB_CNT_W = RF_SB_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_write,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_write,
  output logic              hazard,
  output logic              issue_stall,
  output logic [ADDR_W:0]   busy_count
`ifdef RF_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`endif
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0][SB_CNT_W-1:0] cnt, cnt_nxt;
  logic [NREG-1:0] zero_v, at_max_v;
  logic commit, inc;
  logic [DATA_W-1:0] rs1_nxt_p0, rs2_nxt_p0;

  function automatic logic [ADDR_W:0] popcnt(input logic [NREG-1:0][SB_CNT_W-1:0] c);
    logic [ADDR_W:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++)
      if (c[i] != '0) n = n + 1'b1;
    return n;
  endfunction

  function automatic logic pend(input logic [ADDR_W-1:0] a);
    return (a != ZERO_ADDR) && !zero_v[a] &&
           !(commit && (wb_addr == a) && (cnt[a] == SB_CNT_W'(1)));
  endfunction

  assign commit = we && wb_write && (wb_addr != ZERO_ADDR);

  assign issue_stall = issue_valid && issue_write && (issue_rd != ZERO_ADDR) &&
                       at_max_v[issue_rd] && !(commit && (wb_addr == issue_rd));
  assign inc = we && issue_valid && issue_write && (issue_rd != ZERO_ADDR) && !issue_stall;
  assign hazard = pend(rs1_addr) || pend(rs2_addr);

  assign cnt[0]      = '0;
  assign cnt_nxt[0]  = '0;
  assign zero_v[0]   = 1'b1;
  assign at_max_v[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cell
    rf_sb_cell #(.CNT_W(SB_CNT_W)) u_cell (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc && (issue_rd == ADDR_W'(r))),
      .dec     (commit && (wb_addr == ADDR_W'(r))),
      .cnt     (cnt[r]),
      .cnt_nxt (cnt_nxt[r]),
      .zero    (zero_v[r]),
      .at_max  (at_max_v[r])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Stage p0: read with write-through bypass from the committing writeback.
  always_comb begin
    rs1_nxt_p0 = (commit && (wb_addr == rs1_addr)) ? wb_data : regs[rs1_addr];
    rs2_nxt_p0 = (commit && (wb_addr == rs2_addr)) ? wb_data : regs[rs2_addr];
    if (rs1_addr == ZERO_ADDR) rs1_nxt_p0 = '0;
    if (rs2_addr == ZERO_ADDR) rs2_nxt_p0 = '0;
  end

  // Stage p1: registered read data and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs1_data   <= '0;
      rs2_data   <= '0;
      busy_count <= '0;
    end else begin
      if (we) begin
        rs1_data <= rs1_nxt_p0;
        rs2_data <= rs2_nxt_p0;
      end
      busy_count <= popcnt(cnt_nxt);
    end
  end

`ifdef RF_DEBUG_PORT_EN
  assign dbg_data = (dbg_addr == ZERO_ADDR) ? '0 : regs[dbg_addr];
`endif
endmodule
